// File: rtl/apu_pkg.sv
// Shared APU types and width constants for the channel-1 sweep sequencer.
package apu_pkg;

    localparam int SWEEP_PERIOD_W = 3;
    localparam int SWEEP_SHIFT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CHECK,
        WRITE,
        RECHECK
    } sweep_state_t;

endpackage

// File: rtl/ch1_sweep_timer.sv
// Channel-1 sweep period down-counter clocked by the 128 Hz frame tick.
// A load value of 0 counts 8 ticks; a restart pre-empts a coincident tick.
module ch1_sweep_timer
    import apu_pkg::*;
(
    input  logic                      clk,
    input  logic                      apu_reset,
    input  logic                      tick_128hz,
    input  logic                      ch1_restart,
    input  logic [SWEEP_PERIOD_W-1:0] sweep_period,
    output logic                      expire
);

    localparam logic [SWEEP_PERIOD_W-1:0] CNT_ONE = SWEEP_PERIOD_W'(1);

    logic [SWEEP_PERIOD_W-1:0] cnt;

    assign expire = tick_128hz && !ch1_restart && !apu_reset &&
                    ((cnt == CNT_ONE) || ((cnt == '0) && (sweep_period == '0)));

    always_ff @(posedge clk) begin
        if (apu_reset) begin
            cnt <= '0;
        end else if (ch1_restart || expire) begin
            cnt <= sweep_period;
        end else if (tick_128hz) begin
            cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/ch1_sweep_ctrl.sv
// Channel-1 frequency sweep sequencer: issues load/shift/update strobes to the
// sweep datapath and requests a channel stop on overflow. Optional macro
// CH1_SWEEP_NEG_LOCK_EN adds the negate-mode lockout stop.
//
// state   | meaning
// IDLE    | waiting for a period expiry or restart
// LOAD    | copy shadow frequency into the shift register
// SHIFT   | emit sweep_shift shift pulses, each followed by SHIFT_GAP idle cycles
// CHECK   | sample datapath overflow
// WRITE   | commit the new frequency to shadow and NR13/NR14
// RECHECK | reload for the follow-up overflow check (no write afterwards)
module ch1_sweep_ctrl
    import apu_pkg::*;
#(
    parameter int SHIFT_GAP = 1
) (
    input  logic                     clk,
    input  logic                     apu_reset,
    input  logic                     tick_128hz,
    input  logic                     ch1_restart,
    input  logic [SWEEP_PERIOD_W-1:0] sweep_period,
    input  logic [SWEEP_SHIFT_W-1:0] sweep_shift,
    input  logic                     sweep_negate,
    input  logic                     dp_ovf,
    output logic                     ch1_ld_shift,
    output logic                     ch1_shift_clk,
    output logic                     ch1_freq_upd1,
    output logic                     ch1_freq_upd2,
    output logic                     ch1_sweep_stop,
    output logic                     sweep_busy
);

    localparam logic [1:0]               GAP       = SHIFT_GAP[1:0];
    localparam logic [SWEEP_SHIFT_W-1:0] SHIFT_ONE = SWEEP_SHIFT_W'(1);

    sweep_state_t             state, state_nxt;
    logic                     expire, start;
    logic                     en, no_write;
    logic [SWEEP_SHIFT_W-1:0] shift_cnt;
    logic [1:0]               gap_cnt;
    logic                     shift_done, ovf_stop, neg_stop;
    logic                     ld, sh, upd, busy;

    ch1_sweep_timer u_timer (
        .clk          (clk),
        .apu_reset    (apu_reset),
        .tick_128hz   (tick_128hz),
        .ch1_restart  (ch1_restart),
        .sweep_period (sweep_period),
        .expire       (expire)
    );

    assign start = expire && en && (sweep_period != '0) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (apu_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ld         = 1'b0;
        sh         = 1'b0;
        upd        = 1'b0;
        ovf_stop   = 1'b0;
        shift_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD, RECHECK: begin
                ld        = 1'b1;
                state_nxt = (sweep_shift != '0) ? SHIFT : CHECK;
            end
            SHIFT: begin
                if (gap_cnt == '0) begin
                    sh         = 1'b1;
                    shift_done = (shift_cnt == SHIFT_ONE) && (GAP == 2'd0);
                end else begin
                    shift_done = (gap_cnt == 2'd1) && (shift_cnt == '0);
                end
                if (shift_done) state_nxt = CHECK;
            end
            CHECK: begin
                if (dp_ovf) begin
                    ovf_stop  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = no_write ? IDLE : WRITE;
                end
            end
            WRITE: begin
                upd       = 1'b1;
                state_nxt = RECHECK;
            end
            default: state_nxt = IDLE;
        endcase
        // A restart aborts whatever is running and silences every strobe this cycle.
        if (ch1_restart) begin
            state_nxt = (sweep_shift != '0) ? LOAD : IDLE;
        end
        if (ch1_restart || apu_reset) begin
            ld       = 1'b0;
            sh       = 1'b0;
            upd      = 1'b0;
            ovf_stop = 1'b0;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (apu_reset) begin
            shift_cnt <= '0;
            gap_cnt   <= '0;
        end else if ((state == LOAD) || (state == RECHECK)) begin
            shift_cnt <= sweep_shift;
            gap_cnt   <= '0;
        end else if (state == SHIFT) begin
            if (gap_cnt == '0) begin
                shift_cnt <= shift_cnt - SHIFT_ONE;
                gap_cnt   <= GAP;
            end else begin
                gap_cnt <= gap_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (apu_reset) begin
            en       <= 1'b0;
            no_write <= 1'b0;
        end else begin
            if (ch1_restart) begin
                en <= (sweep_period != '0) || (sweep_shift != '0);
            end else if (ovf_stop || neg_stop) begin
                en <= 1'b0;
            end
            // Restart and recheck passes only look for overflow, never commit.
            if (ch1_restart) begin
                no_write <= 1'b1;
            end else if (start) begin
                no_write <= 1'b0;
            end else if (state == WRITE) begin
                no_write <= 1'b1;
            end
        end
    end

`ifdef CH1_SWEEP_NEG_LOCK_EN
    logic neg_used, negate_q;

    always_ff @(posedge clk) begin
        if (apu_reset) begin
            neg_used <= 1'b0;
            negate_q <= 1'b0;
        end else begin
            negate_q <= sweep_negate;
            if (ch1_restart) begin
                neg_used <= 1'b0;
            end else if ((state == CHECK) && sweep_negate) begin
                neg_used <= 1'b1;
            end
        end
    end

    assign neg_stop = neg_used && negate_q && !sweep_negate && !ch1_restart && !apu_reset;
`else
    logic unused_negate;
    assign unused_negate = sweep_negate;
    assign neg_stop      = 1'b0;
`endif

    assign ch1_ld_shift   = ld;
    assign ch1_shift_clk  = sh;
    assign ch1_freq_upd1  = upd;
    assign ch1_freq_upd2  = upd;
    assign ch1_sweep_stop = ovf_stop | neg_stop;
    assign sweep_busy     = busy;

endmodule

// File: tb/tb_ch1_sweep_ctrl.sv
// Directed and randomized bench for ch1_sweep_ctrl against a cycle-schedule model.
module tb_ch1_sweep_ctrl;

    localparam int G = 1;
    localparam int N = 4096;

    logic       clk = 1'b0;
    logic       apu_reset, tick_128hz, ch1_restart, sweep_negate, dp_ovf;
    logic [2:0] sweep_period, sweep_shift;
    logic       ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2;
    logic       ch1_sweep_stop, sweep_busy;

    always #5 clk = ~clk;

    ch1_sweep_ctrl #(.SHIFT_GAP(G)) dut (
        .clk            (clk),
        .apu_reset      (apu_reset),
        .tick_128hz     (tick_128hz),
        .ch1_restart    (ch1_restart),
        .sweep_period   (sweep_period),
        .sweep_shift    (sweep_shift),
        .sweep_negate   (sweep_negate),
        .dp_ovf         (dp_ovf),
        .ch1_ld_shift   (ch1_ld_shift),
        .ch1_shift_clk  (ch1_shift_clk),
        .ch1_freq_upd1  (ch1_freq_upd1),
        .ch1_freq_upd2  (ch1_freq_upd2),
        .ch1_sweep_stop (ch1_sweep_stop),
        .sweep_busy     (sweep_busy)
    );

    // Expected output schedule per absolute cycle, plus the dp_ovf the bench drives.
    bit e_ld[N], e_sh[N], e_up[N], e_st[N], e_bz[N], ovf_drv[N];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int busy_end = -1;
    bit m_en = 1'b0;
    int m_ticks = 0, m_first = 0, m_per = 0;
    bit ovf_first = 1'b0, ovf_next = 1'b0;

    task automatic chk(input string tag, input logic got, input bit exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        dp_ovf = ovf_drv[cyc];
        @(negedge clk);
        chk("ld_shift",   ch1_ld_shift,   e_ld[cyc]);
        chk("shift_clk",  ch1_shift_clk,  e_sh[cyc]);
        chk("freq_upd1",  ch1_freq_upd1,  e_up[cyc]);
        chk("freq_upd2",  ch1_freq_upd2,  e_up[cyc]);
        chk("sweep_stop", ch1_sweep_stop, e_st[cyc]);
        chk("sweep_busy", sweep_busy,     e_bz[cyc]);
        @(posedge clk);
        #1;
        cyc++;
        apu_reset   = 1'b0;
        tick_128hz  = 1'b0;
        ch1_restart = 1'b0;
        if (cyc >= N - 64) begin
            $display("FAIL cycle_budget observed=%0d limit=%0d", cyc, N - 64);
            $fatal(1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < N; i++) begin
            e_ld[i] = 0; e_sh[i] = 0; e_up[i] = 0; e_st[i] = 0; e_bz[i] = 0; ovf_drv[i] = 0;
        end
    endtask

    // One load + shift train; returns the CHECK cycle.
    task automatic load_shift(input int c0, input int s, output int c);
        c = c0;
        e_ld[c] = 1'b1;
        e_bz[c] = 1'b1;
        c++;
        for (int i = 0; i < s; i++) begin
            e_sh[c] = 1'b1;
            for (int g = 0; g <= G; g++) e_bz[c + g] = 1'b1;
            c += 1 + G;
        end
        e_bz[c] = 1'b1;
    endtask

    task automatic plan(input int k0, input int s, input bit with_write, input bit ovf1, input bit ovf2);
        int c;
        load_shift(k0, s, c);
        if (ovf1) begin
            ovf_drv[c] = 1'b1; e_st[c] = 1'b1; m_en = 1'b0; busy_end = c;
            return;
        end
        if (!with_write) begin
            busy_end = c;
            return;
        end
        c++;
        e_up[c] = 1'b1;
        e_bz[c] = 1'b1;
        load_shift(c + 1, s, c);
        if (ovf2) begin
            ovf_drv[c] = 1'b1; e_st[c] = 1'b1; m_en = 1'b0;
        end
        busy_end = c;
    endtask

    function automatic bit tick_expires(input int n);
        if (m_per == 0) return 1'b0;
        return (n == m_first) || ((n > m_first) && ((n - m_first) % m_per == 0));
    endfunction

    task automatic do_tick();
        tick_128hz = 1'b1;
        m_ticks++;
        if (tick_expires(m_ticks) && m_en && (sweep_period != 3'd0) && (cyc > busy_end))
            plan(cyc + 1, int'(sweep_shift), 1'b1, ovf_first, ovf_next);
        step();
    endtask

    task automatic do_restart(input bit ovf);
        clear_from(cyc);
        ch1_restart = 1'b1;
        m_en     = (sweep_period != 3'd0) || (sweep_shift != 3'd0);
        m_ticks  = 0;
        m_per    = int'(sweep_period);
        m_first  = int'(sweep_period);
        busy_end = cyc;
        if (sweep_shift != 3'd0) plan(cyc + 1, int'(sweep_shift), 1'b0, ovf, 1'b0);
        step();
    endtask

    task automatic do_reset();
        clear_from(cyc);
        apu_reset = 1'b1;
        m_en      = 1'b0;
        busy_end  = cyc;
        step();
    endtask

    initial begin
        apu_reset    = 1'b1;
        tick_128hz   = 1'b0;
        ch1_restart  = 1'b0;
        sweep_negate = 1'b0;
        dp_ovf       = 1'b0;
        sweep_period = 3'd0;
        sweep_shift  = 3'd0;
        @(posedge clk);
        #1;
        cyc = 0;
        apu_reset = 1'b1;
        step();
        run(3);

        // period 2 / shift 1: expiries on ticks 2 and 4, each a full update + recheck.
        sweep_period = 3'd2; sweep_shift = 3'd1;
        do_restart(1'b0);
        run(8);
        for (int i = 0; i < 4; i++) begin do_tick(); run(12); end

        // Simultaneous restart and tick: the tick must not count.
        tick_128hz = 1'b1;
        do_restart(1'b0);
        run(8);
        for (int i = 0; i < 3; i++) begin do_tick(); run(12); end

        // period 0 / shift 3: restart pass only, ticks start nothing.
        sweep_period = 3'd0; sweep_shift = 3'd3;
        do_restart(1'b0);
        run(12);
        for (int i = 0; i < 3; i++) begin do_tick(); run(3); end
        // Period written nonzero while the counter sits at 0: first expiry after 8 ticks.
        sweep_period = 3'd3;
        m_per = 3; m_first = 8; m_ticks = 0;
        for (int i = 0; i < 12; i++) begin do_tick(); run(20); end

        // Overflow at the restart CHECK stops the channel and disables sweep.
        sweep_period = 3'd2; sweep_shift = 3'($urandom_range(1, 3));
        do_restart(1'b1);
        run(10);
        for (int i = 0; i < 4; i++) begin do_tick(); run(3); end

        // Restart during SHIFT of a running update.
        sweep_period = 3'd1; sweep_shift = 3'd3;
        do_restart(1'b0);
        run(10);
        do_tick();
        step();
        do_restart(1'b0);
        run(12);

        // Reset during SHIFT; ticks afterwards start nothing until a restart.
        do_tick();
        step();
        do_reset();
        run(3);
        for (int i = 0; i < 3; i++) begin do_tick(); run(10); end
        sweep_shift = 3'd2;
        do_restart(1'b0);
        run(8);
        do_tick();
        run(14);

        // Negate lockout: negate used in a CHECK, then cleared.
        sweep_period = 3'd1; sweep_shift = 3'd1; sweep_negate = 1'b1;
        do_restart(1'b0);
        run(8);
        do_tick();
        run(12);
        sweep_negate = 1'b0;
`ifdef CH1_SWEEP_NEG_LOCK_EN
        e_st[cyc] = 1'b1;
        m_en = 1'b0;
`endif
        step();
        run(3);
        do_tick();
        run(12);

        // Randomized restarts, shifts, tick spacing and overflow points.
        for (int it = 0; it < 8; it++) begin
            sweep_period = 3'($urandom_range(1, 4));
            sweep_shift  = 3'($urandom_range(0, 3));
            ovf_first    = ($urandom_range(0, 5) == 0);
            ovf_next     = ($urandom_range(0, 3) == 0);
            do_restart($urandom_range(0, 4) == 0);
            run($urandom_range(0, 10));
            for (int t = 0; t < 6; t++) begin
                do_tick();
                run($urandom_range(0, 12));
            end
        end
        ovf_first = 1'b0; ovf_next = 1'b0;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
